// File: rtl/if_stage.sv
// Instruction fetch stage with the IF/ID pipeline register.
// Ports: clk/rst_n; imem_addr/imem_rdata to instruction memory;
// stall, branch_taken/branch_target, jump/jump_target control inputs;
// ir, npc_id, ir_valid, halted, fetch_count toward decode.
module if_stage #(
  parameter int unsigned        ADDR_W   = 10,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] npc_id,
  output logic              ir_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic              vld_q, vld_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [ADDR_W-1:0] pc_inc;
  logic              is_hlt;
  logic              redirect;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign is_hlt   = (imem_rdata[31:26] == 6'b111111);
  assign redirect = branch_taken | jump;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      // Branch is the older instruction, so it wins over jump.
      pc_d    = branch_taken ? branch_target : jump_target;
      ir_d    = NOP_WORD;
      vld_d   = 1'b0;
      state_d = RUN;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == HALT) begin
      state_d = HALT;
    end else begin
      ir_d  = imem_rdata;
      npc_d = pc_inc;
      vld_d = 1'b1;
      cnt_d = cnt_q + 32'd1;
      if (is_hlt) begin
        // PC parks on the HLT word.
        state_d = HALT;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      npc_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign npc_id      = npc_q;
  assign ir_valid    = vld_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// Memory model returns 32'h1000_0000+a with a HLT word at address 7.
module tb_if_stage;

  localparam int AW = 10;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          jump;
  logic [AW-1:0] jump_target;
  logic [31:0]   ir;
  logic [AW-1:0] npc_id;
  logic          ir_valid;
  logic          halted;
  logic [31:0]   fetch_count;

  logic [31:0] mem [0:(1<<AW)-1];

  int n_chk;
  int n_pass;

  if_stage #(
    .ADDR_W  (AW),
    .RESET_PC('0),
    .NOP_WORD(NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .ir           (ir),
    .npc_id       (npc_id),
    .ir_valid     (ir_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  assign imem_rdata = mem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] e_pc,
                         input logic [31:0] e_ir,
                         input logic [31:0] e_npc,
                         input logic        e_vld,
                         input logic        e_hlt,
                         input logic [31:0] e_cnt);
    chk({tag, ".pc"},  32'(imem_addr), e_pc);
    chk({tag, ".ir"},  ir, e_ir);
    chk({tag, ".npc"}, 32'(npc_id), e_npc);
    chk({tag, ".vld"}, 32'(ir_valid), 32'(e_vld));
    chk({tag, ".hlt"}, 32'(halted), 32'(e_hlt));
    chk({tag, ".cnt"}, fetch_count, e_cnt);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'h1000_0000 + a;
    mem[7] = HLT;

    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    #2;
    chk_all("rst", 0, NOP, 0, 0, 0, 0);
    #1 rst_n = 1'b1;

    // Sequential fetch from reset.
    for (int i = 0; i < 4; i++) step();
    chk_all("seq4", 4, 32'h1000_0003, 4, 1, 0, 4);
    step();
    chk_all("seq5", 5, 32'h1000_0004, 5, 1, 0, 5);

    // Stall three cycles at pc=5.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 5, 32'h1000_0004, 5, 1, 0, 5);
    end
    stall = 1'b0;
    step();
    chk_all("unstall", 6, 32'h1000_0005, 6, 1, 0, 6);

    // Branch beats jump, even under stall.
    branch_taken  = 1'b1;
    branch_target = AW'(20);
    jump          = 1'b1;
    jump_target   = AW'(40);
    stall         = 1'b1;
    step();
    branch_taken = 1'b0;
    jump         = 1'b0;
    stall        = 1'b0;
    chk_all("br", 20, NOP, 6, 0, 0, 6);
    step();
    chk_all("br_tgt", 21, 32'h1000_0014, 21, 1, 0, 7);

    // Jump onto the HLT word.
    jump        = 1'b1;
    jump_target = AW'(7);
    step();
    jump = 1'b0;
    chk_all("j7", 7, NOP, 21, 0, 0, 7);
    step();
    chk_all("hlt", 7, HLT, 8, 1, 1, 8);
    for (int i = 0; i < 10; i++) step();
    chk_all("hlt10", 7, HLT, 8, 1, 1, 8);

    // Jump releases HALT.
    jump        = 1'b1;
    jump_target = AW'(2);
    step();
    jump = 1'b0;
    chk_all("unhlt", 2, NOP, 8, 0, 0, 8);
    step();
    chk_all("unhlt2", 3, 32'h1000_0002, 3, 1, 0, 9);

    // PC wrap at the top of the address space.
    jump        = 1'b1;
    jump_target = AW'((1 << AW) - 1);
    step();
    jump = 1'b0;
    chk_all("jtop", (1 << AW) - 1, NOP, 3, 0, 0, 9);
    step();
    chk_all("wrap", 0, 32'h1000_03FF, 0, 1, 0, 10);

    // Async reset while halted and stalled.
    jump        = 1'b1;
    jump_target = AW'(7);
    step();
    jump = 1'b0;
    step();
    chk_all("hlt_b", 7, HLT, 8, 1, 1, 11);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 0, NOP, 0, 0, 0, 0);
    step();
    chk_all("arst_hold", 0, NOP, 0, 0, 0, 0);
    stall = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk_all("restart", 1, 32'h1000_0000, 1, 1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
